// File: rtl/alut_mem_arb8_pkg.sv
// Shared types and default sizes for the ALUT8 lookup RAM arbiter.
package alut_pkg8;

  localparam int unsigned DW8_DEFAULT       = 83;
  localparam int unsigned AW8_DEFAULT       = 8;
  localparam int unsigned MAX_WAIT8_DEFAULT = 4;

  typedef enum logic [0:0] {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

endpackage

// File: rtl/alut_mem_arb8.sv
// Single-port ALUT8 RAM arbiter: add path has priority, age path is starvation-bounded
// and may lock the RAM for read-modify-write; one registered access issued per cycle.
module alut_mem_arb8
  import alut_pkg8::*;
#(
  parameter int unsigned DW8       = DW8_DEFAULT,
  parameter int unsigned AW8       = AW8_DEFAULT,
  parameter int unsigned MAX_WAIT8 = MAX_WAIT8_DEFAULT
) (
  input  logic           pclk8,
  input  logic           p_reset8,
  input  logic           add_req8,
  input  logic           add_write8,
  input  logic [AW8-1:0] add_addr8,
  input  logic [DW8-1:0] add_wdata8,
  output logic           add_gnt8,
  output logic           add_rvalid8,
  input  logic           age_req8,
  input  logic           age_write8,
  input  logic [AW8-1:0] age_addr8,
  input  logic [DW8-1:0] age_wdata8,
  input  logic           age_lock8,
  output logic           age_gnt8,
  output logic           age_rvalid8,
  output logic [DW8-1:0] rdata8,
  output logic           mem_cs8,
  output logic           mem_we8,
  output logic [AW8-1:0] mem_addr8,
  output logic [DW8-1:0] mem_wdata8,
  input  logic [DW8-1:0] mem_rdata8
);

  localparam int unsigned WCW = $clog2(MAX_WAIT8 + 1);
  localparam logic [WCW-1:0] WaitMax = WCW'(MAX_WAIT8);

  arb_state_e     state_q, state_d;
  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
  logic           lock_hold;
  logic           add_rd_q, age_rd_q;

  // Lock persists only while age_lock8 stays high; the release cycle is arbitrated normally.
  assign lock_hold = (state_q == LOCK) && age_lock8;

  always_comb begin
    add_gnt8 = 1'b0;
    age_gnt8 = 1'b0;
    if (!p_reset8) begin
      if (lock_hold) begin
        age_gnt8 = age_req8;
      end else if (age_req8 && (wait_cnt_q == WaitMax)) begin
        age_gnt8 = 1'b1;
      end else if (add_req8) begin
        add_gnt8 = 1'b1;
      end else if (age_req8) begin
        age_gnt8 = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = (age_lock8 && (lock_hold || age_gnt8)) ? LOCK : ARB;
    if (!age_req8 || age_gnt8) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != WaitMax) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end else begin
      wait_cnt_d = wait_cnt_q;
    end
  end

  always_ff @(posedge pclk8 or posedge p_reset8) begin
    if (p_reset8) begin
      state_q     <= ARB;
      wait_cnt_q  <= '0;
      mem_cs8     <= 1'b0;
      mem_we8     <= 1'b0;
      mem_addr8   <= '0;
      mem_wdata8  <= '0;
      add_rd_q    <= 1'b0;
      age_rd_q    <= 1'b0;
      add_rvalid8 <= 1'b0;
      age_rvalid8 <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_cs8     <= add_gnt8 | age_gnt8;
      mem_we8     <= (add_gnt8 & add_write8) | (age_gnt8 & age_write8);
      if (add_gnt8) begin
        mem_addr8  <= add_addr8;
        mem_wdata8 <= add_wdata8;
      end else if (age_gnt8) begin
        mem_addr8  <= age_addr8;
        mem_wdata8 <= age_wdata8;
      end
      // Read tags trail the issue stage by one cycle to line up with RAM output.
      add_rd_q    <= add_gnt8 & ~add_write8;
      age_rd_q    <= age_gnt8 & ~age_write8;
      add_rvalid8 <= add_rd_q;
      age_rvalid8 <= age_rd_q;
    end
  end

  assign rdata8 = mem_rdata8;

endmodule

// File: tb/tb_alut_mem_arb8.sv
// Directed self-checking bench for alut_mem_arb8 with a behavioural single-port RAM.
module tb_alut_mem_arb8;

  localparam int DW = 83;
  localparam int AW = 8;

  logic          pclk8 = 1'b0;
  logic          p_reset8;
  logic          add_req8, add_write8, age_req8, age_write8, age_lock8;
  logic [AW-1:0] add_addr8, age_addr8, mem_addr8;
  logic [DW-1:0] add_wdata8, age_wdata8, rdata8, mem_wdata8, mem_rdata8;
  logic          add_gnt8, add_rvalid8, age_gnt8, age_rvalid8, mem_cs8, mem_we8;

  int checks = 0;
  int failures = 0;

  alut_mem_arb8 dut (
    .pclk8      (pclk8),
    .p_reset8   (p_reset8),
    .add_req8   (add_req8),
    .add_write8 (add_write8),
    .add_addr8  (add_addr8),
    .add_wdata8 (add_wdata8),
    .add_gnt8   (add_gnt8),
    .add_rvalid8(add_rvalid8),
    .age_req8   (age_req8),
    .age_write8 (age_write8),
    .age_addr8  (age_addr8),
    .age_wdata8 (age_wdata8),
    .age_lock8  (age_lock8),
    .age_gnt8   (age_gnt8),
    .age_rvalid8(age_rvalid8),
    .rdata8     (rdata8),
    .mem_cs8    (mem_cs8),
    .mem_we8    (mem_we8),
    .mem_addr8  (mem_addr8),
    .mem_wdata8 (mem_wdata8),
    .mem_rdata8 (mem_rdata8)
  );

  always #5 pclk8 = ~pclk8;

  function automatic logic [DW-1:0] word_of(input logic [7:0] a);
    return {a, ~a, 67'(a) * 67'd31 + 67'd7};
  endfunction

  // Unwritten locations read back as word_of(addr).
  logic [DW-1:0] ram [256];
  logic [255:0]  written;
  logic          ram_clr;

  always @(posedge pclk8) begin
    if (ram_clr) begin
      written <= '0;
    end else if (mem_cs8) begin
      if (mem_we8) begin
        ram[mem_addr8]     <= mem_wdata8;
        written[mem_addr8] <= 1'b1;
      end else begin
        mem_rdata8 <= written[mem_addr8] ? ram[mem_addr8] : word_of(mem_addr8);
      end
    end
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge pclk8);
  endtask

  localparam logic [DW-1:0] DataA = 83'h5_0000_DEAD_BEEF_0040;
  localparam logic [DW-1:0] DataB = 83'h2_1234_5678_9ABC_0007;

  bit            exp_age [20];
  logic [AW-1:0] exp_addr[20];
  int            ai, gi;
  bit            is_age;

  initial begin
    p_reset8 = 1'b1; ram_clr = 1'b1;
    add_req8 = 1'b1; add_write8 = 1'b0; add_addr8 = '0; add_wdata8 = '0;
    age_req8 = 1'b0; age_write8 = 1'b0; age_addr8 = '0; age_wdata8 = '0; age_lock8 = 1'b0;

    // Reset state, with a request pending
    cyc(); cyc(); ram_clr = 1'b0;
    #1;
    chk1("rst_add_gnt", add_gnt8, 1'b0);
    chk1("rst_age_gnt", age_gnt8, 1'b0);
    chk1("rst_add_rvalid", add_rvalid8, 1'b0);
    chk1("rst_age_rvalid", age_rvalid8, 1'b0);
    chk1("rst_mem_cs", mem_cs8, 1'b0);
    chk1("rst_mem_we", mem_we8, 1'b0);
    chk8("rst_mem_addr", mem_addr8, 8'h00);
    chkw("rst_mem_wdata", mem_wdata8, '0);
    cyc(); p_reset8 = 1'b0; add_req8 = 1'b0;

    // Single add read of 0x12
    cyc(); add_req8 = 1'b1; add_addr8 = 8'h12;
    #1; chk1("rd12_add_gnt", add_gnt8, 1'b1); chk1("rd12_age_gnt", age_gnt8, 1'b0);
    cyc(); add_req8 = 1'b0;
    #1; chk1("rd12_cs", mem_cs8, 1'b1); chk1("rd12_we", mem_we8, 1'b0);
    chk8("rd12_addr", mem_addr8, 8'h12); chk1("rd12_early_rvalid", add_rvalid8, 1'b0);
    cyc();
    #1; chk1("rd12_rvalid", add_rvalid8, 1'b1); chkw("rd12_rdata", rdata8, word_of(8'h12));
    chk1("rd12_age_rvalid", age_rvalid8, 1'b0); chk1("rd12_cs_idle", mem_cs8, 1'b0);
    chk8("rd12_addr_hold", mem_addr8, 8'h12);
    cyc();
    #1; chk1("rd12_rvalid_pulse", add_rvalid8, 1'b0);

    // Contention: add wins until age has waited four cycles
    cyc(); add_req8 = 1'b1; add_addr8 = 8'h20; age_req8 = 1'b1; age_addr8 = 8'h30;
    #1; chk1("cont1_add_gnt", add_gnt8, 1'b1); chk1("cont1_age_gnt", age_gnt8, 1'b0);
    for (int k = 2; k <= 4; k++) begin
      cyc();
      #1; chk1("cont_add_gnt", add_gnt8, 1'b1); chk1("cont_age_gnt", age_gnt8, 1'b0);
    end
    cyc();
    #1; chk1("cont5_age_gnt", age_gnt8, 1'b1); chk1("cont5_add_gnt", add_gnt8, 1'b0);
    cyc(); age_req8 = 1'b0;
    #1; chk1("cont6_add_gnt", add_gnt8, 1'b1); chk8("cont6_mem_addr", mem_addr8, 8'h30);
    cyc(); add_req8 = 1'b0;
    #1; chk1("cont7_age_rvalid", age_rvalid8, 1'b1); chk1("cont7_add_rvalid", add_rvalid8, 1'b0);
    chkw("cont7_rdata", rdata8, word_of(8'h30)); chk8("cont7_mem_addr", mem_addr8, 8'h20);
    cyc();
    #1; chk1("cont8_add_rvalid", add_rvalid8, 1'b1); chk1("cont8_age_rvalid", age_rvalid8, 1'b0);
    chkw("cont8_rdata", rdata8, word_of(8'h20));
    cyc();

    // Locked read-modify-write of 0x40 blocks the add path
    cyc(); age_req8 = 1'b1; age_write8 = 1'b0; age_addr8 = 8'h40; age_lock8 = 1'b1;
    #1; chk1("lockA_age_gnt", age_gnt8, 1'b1);
    cyc(); age_write8 = 1'b1; age_wdata8 = DataA; add_req8 = 1'b1; add_addr8 = 8'h50;
    #1; chk1("lockB_age_gnt", age_gnt8, 1'b1); chk1("lockB_add_gnt", add_gnt8, 1'b0);
    chk8("lockB_mem_addr", mem_addr8, 8'h40); chk1("lockB_mem_we", mem_we8, 1'b0);
    cyc(); age_req8 = 1'b0;
    #1; chk1("lockC_add_gnt", add_gnt8, 1'b0); chk1("lockC_age_gnt", age_gnt8, 1'b0);
    chk1("lockC_mem_we", mem_we8, 1'b1); chkw("lockC_mem_wdata", mem_wdata8, DataA);
    chk1("lockC_age_rvalid", age_rvalid8, 1'b1); chkw("lockC_rdata", rdata8, word_of(8'h40));
    cyc(); age_lock8 = 1'b0;
    #1; chk1("lockD_add_gnt", add_gnt8, 1'b1); chk1("lockD_mem_cs", mem_cs8, 1'b0);
    cyc(); add_addr8 = 8'h40;
    #1; chk1("lockE_add_gnt", add_gnt8, 1'b1); chk1("lockE_age_rvalid", age_rvalid8, 1'b0);
    chk8("lockE_mem_addr", mem_addr8, 8'h50);
    cyc(); add_req8 = 1'b0;
    #1; chk1("lockF_add_rvalid", add_rvalid8, 1'b1); chkw("lockF_rdata", rdata8, word_of(8'h50));
    cyc();
    #1; chk1("lockG_add_rvalid", add_rvalid8, 1'b1); chkw("lockG_rdata", rdata8, DataA);

    // Back-to-back write then read of 0x07
    cyc(); add_req8 = 1'b1; add_write8 = 1'b1; add_addr8 = 8'h07; add_wdata8 = DataB;
    #1; chk1("wr07_gnt", add_gnt8, 1'b1);
    cyc(); add_write8 = 1'b0;
    #1; chk1("rd07_gnt", add_gnt8, 1'b1); chk1("wr07_mem_we", mem_we8, 1'b1);
    chkw("wr07_mem_wdata", mem_wdata8, DataB);
    cyc(); add_req8 = 1'b0;
    #1; chk1("wr07_no_rvalid", add_rvalid8, 1'b0); chk1("rd07_mem_we", mem_we8, 1'b0);
    chk8("rd07_mem_addr", mem_addr8, 8'h07);
    cyc();
    #1; chk1("rd07_rvalid", add_rvalid8, 1'b1); chkw("rd07_rdata", rdata8, DataB);
    cyc();

    // Sustained contention: add reads at 0x80+, age writes at 0xC0+; age wins every fifth cycle
    ai = 0; gi = 0;
    for (int k = 0; k < 22; k++) begin
      cyc();
      if (k < 20) begin
        add_req8 = 1'b1; add_write8 = 1'b0; add_addr8 = 8'(8'h80 + ai);
        age_req8 = 1'b1; age_write8 = 1'b1; age_addr8 = 8'(8'hC0 + gi);
        age_wdata8 = DW'(gi + 100);
      end else begin
        add_req8 = 1'b0; age_req8 = 1'b0;
      end
      #1;
      if (k < 20) begin
        is_age = ((k % 5) == 4);
        chk1("alt_age_gnt", age_gnt8, is_age);
        chk1("alt_add_gnt", add_gnt8, !is_age);
        exp_age[k]  = is_age;
        exp_addr[k] = is_age ? 8'(8'hC0 + gi) : 8'(8'h80 + ai);
        if (is_age) gi++;
        else ai++;
      end
      if (k >= 1 && k <= 20) begin
        chk1("alt_mem_cs", mem_cs8, 1'b1);
        chk1("alt_mem_we", mem_we8, exp_age[k-1]);
        chk8("alt_mem_addr", mem_addr8, exp_addr[k-1]);
      end
      if (k >= 2) begin
        chk1("alt_add_rvalid", add_rvalid8, !exp_age[k-2]);
        chk1("alt_age_rvalid", age_rvalid8, 1'b0);
        if (!exp_age[k-2]) chkw("alt_rdata", rdata8, word_of(exp_addr[k-2]));
      end
    end

    // Reset asserted while a read is in flight
    cyc(); add_req8 = 1'b1; add_write8 = 1'b0; add_addr8 = 8'h12;
    #1; chk1("rstmid_gnt", add_gnt8, 1'b1);
    cyc(); p_reset8 = 1'b1;
    #1; chk1("rstmid_mem_cs", mem_cs8, 1'b0); chk8("rstmid_mem_addr", mem_addr8, 8'h00);
    chk1("rstmid_add_gnt", add_gnt8, 1'b0); chk1("rstmid_add_rvalid", add_rvalid8, 1'b0);
    cyc(); p_reset8 = 1'b0; add_req8 = 1'b0;
    #1; chk1("rstmid_rvalid1", add_rvalid8, 1'b0);
    cyc();
    #1; chk1("rstmid_rvalid2", add_rvalid8, 1'b0); chk1("rstmid_cs_idle", mem_cs8, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
